// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline register file.
package mips_pkg;

    localparam int unsigned INST_SZ     = 32;
    localparam int unsigned REG_ADDR_SZ = 5;
    localparam int unsigned NUM_REGS    = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Debug-dump engine states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port: $zero check plus write-through bypass.
module reg_read_port #(
    parameter int unsigned INST_SZ     = 32,
    parameter int unsigned REG_ADDR_SZ = 5
) (
    input  logic [REG_ADDR_SZ-1:0] addr,
    input  logic                   we,
    input  logic [REG_ADDR_SZ-1:0] write_addr,
    input  logic [INST_SZ-1:0]     write_data,
    input  logic [INST_SZ-1:0]     array_data,
    output logic [INST_SZ-1:0]     data_c
);

    import mips_pkg::*;

    // $zero wins, then the in-flight WB write, then the stored value
    always_comb begin
        data_c = array_data;
        if (addr == REG_ADDR_SZ'(REG_ZERO)) begin
            data_c = '0;
        end else if (we && (addr == write_addr)) begin
            data_c = write_data;
        end
    end

endmodule

// File: rtl/register_file.sv
// 32 x 32 MIPS register file with bypassed reads and a serial debug dump.
module register_file #(
    parameter int unsigned INST_SZ     = 32,
    parameter int unsigned REG_ADDR_SZ = 5,
    parameter int unsigned NUM_REGS    = 32
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_reg_write_W,
    input  logic [REG_ADDR_SZ-1:0] i_write_register_W,
    input  logic [INST_SZ-1:0]     i_write_data_W,
    input  logic [REG_ADDR_SZ-1:0] i_read_register_1,
    input  logic [REG_ADDR_SZ-1:0] i_read_register_2,
    output logic [INST_SZ-1:0]     o_read_data_1,
    output logic [INST_SZ-1:0]     o_read_data_2,
    input  logic                   i_dbg_dump,
    output logic                   o_dbg_valid,
    output logic [REG_ADDR_SZ-1:0] o_dbg_index,
    output logic [INST_SZ-1:0]     o_dbg_data,
    output logic                   o_dbg_done
);

    import mips_pkg::*;

    localparam logic [REG_ADDR_SZ-1:0] LAST_IDX = REG_ADDR_SZ'(NUM_REGS - 1);

    logic [INST_SZ-1:0]     regs [NUM_REGS];
    logic                   we;
    dump_state_t            state;
    logic [REG_ADDR_SZ-1:0] idx;

    assign we = i_reg_write_W & i_enable &
                (i_write_register_W != REG_ADDR_SZ'(REG_ZERO));

    // Storage array; register 0 is never written because we excludes it
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[i_write_register_W] <= i_write_data_W;
        end
    end

    // Dump engine: one word per cycle from the array (pre-write contents), then a done pulse
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            idx         <= '0;
            o_dbg_valid <= 1'b0;
            o_dbg_index <= '0;
            o_dbg_data  <= '0;
            o_dbg_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_dbg_valid <= 1'b0;
                    o_dbg_done  <= 1'b0;
                    if (i_dbg_dump) begin
                        idx   <= '0;
                        state <= DUMP;
                    end
                end
                DUMP: begin
                    o_dbg_valid <= 1'b1;
                    o_dbg_index <= idx;
                    o_dbg_data  <= regs[idx];
                    idx         <= idx + REG_ADDR_SZ'(1);
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    o_dbg_valid <= 1'b0;
                    if (!o_dbg_done) begin
                        o_dbg_done <= 1'b1;
                    end else begin
                        o_dbg_done <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    o_dbg_valid <= 1'b0;
                    o_dbg_done  <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    reg_read_port #(
        .INST_SZ    (INST_SZ),
        .REG_ADDR_SZ(REG_ADDR_SZ)
    ) u_port_1 (
        .addr      (i_read_register_1),
        .we        (we),
        .write_addr(i_write_register_W),
        .write_data(i_write_data_W),
        .array_data(regs[i_read_register_1]),
        .data_c    (o_read_data_1)
    );

    reg_read_port #(
        .INST_SZ    (INST_SZ),
        .REG_ADDR_SZ(REG_ADDR_SZ)
    ) u_port_2 (
        .addr      (i_read_register_2),
        .we        (we),
        .write_addr(i_write_register_W),
        .write_data(i_write_data_W),
        .array_data(regs[i_read_register_2]),
        .data_c    (o_read_data_2)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

    logic        i_clk;
    logic        i_reset;
    logic        i_enable;
    logic        i_reg_write_W;
    logic [4:0]  i_write_register_W;
    logic [31:0] i_write_data_W;
    logic [4:0]  i_read_register_1;
    logic [4:0]  i_read_register_2;
    logic [31:0] o_read_data_1;
    logic [31:0] o_read_data_2;
    logic        i_dbg_dump;
    logic        o_dbg_valid;
    logic [4:0]  o_dbg_index;
    logic [31:0] o_dbg_data;
    logic        o_dbg_done;

    int n_checks;
    int n_bad;

    register_file dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_enable          (i_enable),
        .i_reg_write_W     (i_reg_write_W),
        .i_write_register_W(i_write_register_W),
        .i_write_data_W    (i_write_data_W),
        .i_read_register_1 (i_read_register_1),
        .i_read_register_2 (i_read_register_2),
        .o_read_data_1     (o_read_data_1),
        .o_read_data_2     (o_read_data_2),
        .i_dbg_dump        (i_dbg_dump),
        .o_dbg_valid       (o_dbg_valid),
        .o_dbg_index       (o_dbg_index),
        .o_dbg_data        (o_dbg_data),
        .o_dbg_done        (o_dbg_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        i_reg_write_W      = 1'b1;
        i_write_register_W = a;
        i_write_data_W     = d;
        step();
        i_reg_write_W      = 1'b0;
    endtask

    initial begin
        int done_seen;
        int valid_seen;
        n_checks = 0;
        n_bad    = 0;
        i_reset            = 1'b1;
        i_enable           = 1'b1;
        i_reg_write_W      = 1'b0;
        i_write_register_W = 5'd0;
        i_write_data_W     = 32'h0;
        i_read_register_1  = 5'd1;
        i_read_register_2  = 5'd2;
        i_dbg_dump         = 1'b0;
        step();
        step();
        i_reset = 1'b0;

        // reset state
        check("rst_valid", 32'(o_dbg_valid), 32'h0);
        check("rst_done",  32'(o_dbg_done),  32'h0);
        check("rst_index", 32'(o_dbg_index), 32'h0);
        check("rst_data",  o_dbg_data,       32'h0);
        check("rst_r1",    o_read_data_1,    32'h0);
        check("rst_r2",    o_read_data_2,    32'h0);

        // plain write then read back
        write_reg(5'd5, 32'h12345678);
        i_read_register_1 = 5'd5;
        #1;
        check("r5_read", o_read_data_1, 32'h12345678);

        // writes to $zero are dropped, also no bypass
        i_read_register_1  = 5'd0;
        i_reg_write_W      = 1'b1;
        i_write_register_W = 5'd0;
        i_write_data_W     = 32'hFFFFFFFF;
        #1;
        check("r0_bypass", o_read_data_1, 32'h0);
        step();
        i_reg_write_W = 1'b0;
        #1;
        check("r0_after", o_read_data_1, 32'h0);

        // same-cycle bypass on both ports
        i_read_register_1  = 5'd7;
        i_read_register_2  = 5'd7;
        i_reg_write_W      = 1'b1;
        i_write_register_W = 5'd7;
        i_write_data_W     = 32'hCAFEBABE;
        #1;
        check("r7_byp_p1", o_read_data_1, 32'hCAFEBABE);
        check("r7_byp_p2", o_read_data_2, 32'hCAFEBABE);
        step();
        i_reg_write_W  = 1'b0;
        i_write_data_W = 32'h0;
        #1;
        check("r7_arr_p1", o_read_data_1, 32'hCAFEBABE);
        check("r7_arr_p2", o_read_data_2, 32'hCAFEBABE);

        // disabled write: no bypass, no update
        i_enable           = 1'b0;
        i_read_register_1  = 5'd3;
        i_reg_write_W      = 1'b1;
        i_write_register_W = 5'd3;
        i_write_data_W     = 32'h0000AAAA;
        #1;
        check("r3_nobyp", o_read_data_1, 32'h0);
        step();
        i_reg_write_W = 1'b0;
        i_enable      = 1'b1;
        #1;
        check("r3_kept", o_read_data_1, 32'h0);

        // preload rN = N*0x11
        for (int n = 1; n < 32; n++) begin
            write_reg(5'(n), 32'(n * 32'h11));
        end
        i_read_register_1 = 5'd31;
        i_read_register_2 = 5'd1;
        #1;
        check("pre_r31", o_read_data_1, 32'h0000020F);
        check("pre_r1",  o_read_data_2, 32'h00000011);

        // full dump, with a second request mid-dump that must be ignored
        i_dbg_dump = 1'b1;
        step();
        i_dbg_dump = 1'b0;
        for (int n = 0; n < 32; n++) begin
            if (n == 4) i_dbg_dump = 1'b1;
            step();
            i_dbg_dump = 1'b0;
            check($sformatf("dump_valid_%0d", n), 32'(o_dbg_valid), 32'h1);
            check($sformatf("dump_index_%0d", n), 32'(o_dbg_index), 32'(n));
            check($sformatf("dump_data_%0d", n),  o_dbg_data,       32'(n * 32'h11));
            check($sformatf("dump_done_%0d", n),  32'(o_dbg_done),  32'h0);
        end
        step();
        check("done_pulse",   32'(o_dbg_done),  32'h1);
        check("done_valid",   32'(o_dbg_valid), 32'h0);
        step();
        check("done_drop",    32'(o_dbg_done),  32'h0);
        check("post_valid",   32'(o_dbg_valid), 32'h0);
        step();
        check("idle_done",    32'(o_dbg_done),  32'h0);
        check("idle_valid",   32'(o_dbg_valid), 32'h0);

        // reset mid-dump aborts without a done pulse
        i_dbg_dump = 1'b1;
        step();
        i_dbg_dump = 1'b0;
        for (int n = 0; n < 11; n++) step();
        check("abort_idx10", 32'(o_dbg_index), 32'd10);
        check("abort_dat10", o_dbg_data,       32'h000000AA);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        check("abort_valid", 32'(o_dbg_valid), 32'h0);
        check("abort_done",  32'(o_dbg_done),  32'h0);
        check("abort_index", 32'(o_dbg_index), 32'h0);
        check("abort_data",  o_dbg_data,       32'h0);
        done_seen  = 0;
        valid_seen = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (o_dbg_done)  done_seen++;
            if (o_dbg_valid) valid_seen++;
        end
        check("abort_no_done",  32'(done_seen),  32'h0);
        check("abort_no_valid", 32'(valid_seen), 32'h0);
        for (int n = 0; n < 32; n++) begin
            i_read_register_1 = 5'(n);
            i_read_register_2 = 5'(31 - n);
            #1;
            check($sformatf("clr_p1_r%0d", n),      o_read_data_1, 32'h0);
            check($sformatf("clr_p2_r%0d", 31 - n), o_read_data_2, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
